// File: rtl/cpu_req_sequencer.sv
// rtl/cpu_req_sequencer.sv - command FIFO replayed to VMEM as CPU handshakes and operation pulses

// Command queue: registered ready, count-based full/empty, pointers wrap modulo DEPTH
module cpu_req_seq_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic         nonempty_next
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push       = s_tvalid && s_tready;
  assign do_pop        = m_tready && m_tvalid;
  assign m_tvalid      = (count != '0);
  assign m_tdata       = mem[rd_ptr];
  assign nonempty_next = (count_next != '0);

  // Occupancy after this edge; also drives the registered ready and the sequencer's busy
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage array kept free of reset so it can map onto plain registers or RAM
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // Pointer, count and ready bookkeeping; reset discards any queued entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      s_tready <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      s_tready <= (count_next != (AW + 1)'(DEPTH));
    end
  end
endmodule

// Sequencer: pops commands and drives the CPU request handshake or an operation pulse
module cpu_req_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int OP_PULSE = 10,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              CPU_Request,
  output logic              CPU_WE,
  output logic [ADDR_W-1:0] CPU_Address,
  output logic [DATA_W-1:0] CPU_WData,
  input  logic [DATA_W-1:0] CPU_RData,
  input  logic              CPU_ACK,
  output logic              OP_Request,
  output logic [3:0]        OPERATIONS,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              timeout_err,
  output logic              illegal_err,
  output logic [CNT_W-1:0]  n_reads,
  output logic [CNT_W-1:0]  n_writes,
  output logic [CNT_W-1:0]  n_ops,
  output logic [CNT_W-1:0]  n_timeouts
);
  localparam int EW     = 4 + ADDR_W + DATA_W;
  localparam int PW     = $clog2(OP_PULSE + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_OPS} state_t;

  state_t            state;
  logic [PW-1:0]     pulse_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              head_valid;
  logic [EW-1:0]     head;
  logic [3:0]        head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              fifo_nonempty_next;
  logic              timeout_hit;

  assign head_op   = head[EW-1 -: 4];
  assign head_addr = head[DATA_W +: ADDR_W];
  assign head_data = head[DATA_W-1:0];

  // A new command is only taken once VMEM has released ACK from the previous one
  assign pop = (state == S_IDLE) && head_valid && !CPU_ACK;

  // The wait counter holds cycles already spent in the phase; this edge would be number TIMEOUT
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  cpu_req_seq_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk           (clk),
    .rst           (rst),
    .s_tvalid      (cmd_valid),
    .s_tready      (cmd_ready),
    .s_tdata       ({cmd_op, cmd_addr, cmd_data}),
    .m_tvalid      (head_valid),
    .m_tready      (pop),
    .m_tdata       (head),
    .nonempty_next (fifo_nonempty_next)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Handshake FSM with registered outputs, timeouts and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pulse_cnt   <= '0;
      wait_cnt    <= '0;
      CPU_Request <= 1'b0;
      CPU_WE      <= 1'b0;
      CPU_Address <= '0;
      CPU_WData   <= '0;
      OP_Request  <= 1'b0;
      OPERATIONS  <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      illegal_err <= 1'b0;
      n_reads     <= '0;
      n_writes    <= '0;
      n_ops       <= '0;
      n_timeouts  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= fifo_nonempty_next;
          if (pop) begin
            case (head_op)
              4'd0, 4'd1: begin
                CPU_Address <= head_addr;
                CPU_WE      <= head_op[0];
                CPU_WData   <= head_data;
                CPU_Request <= 1'b1;
                wait_cnt    <= '0;
                busy        <= 1'b1;
                state       <= S_REQ;
              end
              4'd2, 4'd3, 4'd4, 4'd8, 4'd9: begin
                OPERATIONS <= head_op;
                OP_Request <= 1'b1;
                pulse_cnt  <= PW'(OP_PULSE - 1);
                busy       <= 1'b1;
                state      <= S_OPS;
              end
              default: begin
                illegal_err <= 1'b1;
              end
            endcase
          end
        end
        S_REQ: begin
          busy <= 1'b1;
          if (CPU_ACK) begin
            CPU_Request <= 1'b0;
            if (!CPU_WE) begin
              rd_data  <= CPU_RData;
              rd_valid <= 1'b1;
              n_reads  <= sat_inc(n_reads);
            end else begin
              n_writes <= sat_inc(n_writes);
            end
            wait_cnt <= '0;
            state    <= S_REL;
          end else if (timeout_hit) begin
            CPU_Request <= 1'b0;
            timeout_err <= 1'b1;
            n_timeouts  <= sat_inc(n_timeouts);
            wait_cnt    <= '0;
            state       <= S_REL;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_REL: begin
          if (!CPU_ACK) begin
            busy  <= fifo_nonempty_next;
            state <= S_IDLE;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            n_timeouts  <= sat_inc(n_timeouts);
            busy        <= fifo_nonempty_next;
            state       <= S_IDLE;
          end else begin
            busy <= 1'b1;
            if (TIMEOUT != 0) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_OPS: begin
          if (pulse_cnt == '0) begin
            OP_Request <= 1'b0;
            n_ops      <= sat_inc(n_ops);
            busy       <= fifo_nonempty_next;
            state      <= S_IDLE;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
            busy      <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_req_sequencer.sv
// tb/tb_cpu_req_sequencer.sv - directed bench for cpu_req_sequencer with a small VMEM model
module tb_cpu_req_sequencer;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int OP_PULSE = 10;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              CPU_Request;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_Address;
  logic [DATA_W-1:0] CPU_WData;
  logic [DATA_W-1:0] CPU_RData = '0;
  logic              CPU_ACK = 1'b0;
  logic              OP_Request;
  logic [3:0]        OPERATIONS;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              timeout_err;
  logic              illegal_err;
  logic [CNT_W-1:0]  n_reads;
  logic [CNT_W-1:0]  n_writes;
  logic [CNT_W-1:0]  n_ops;
  logic [CNT_W-1:0]  n_timeouts;

  int n_checks = 0;
  int n_err    = 0;

  // VMEM model controls and monitor state
  logic              ack_en    = 1'b1;
  int                ack_delay = 3;
  logic [DATA_W-1:0] rdata_val = 32'hDEAD_BEEF;
  int                req_cyc   = 0;
  logic [ADDR_W-1:0] addr_log[$];
  logic [3:0]        op_codes[$];
  int                op_lens[$];
  int                req_run = 0;
  int                op_run  = 0;
  int                last_req_len = 0;
  int                rd_pulses = 0;
  int                rdv_long = 0;
  int                rdv_req_err = 0;
  int                stab_err = 0;
  logic              cap_we = 1'b0;
  logic [DATA_W-1:0] cap_wd = '0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic              prev_req = 1'b0;
  logic              prev_op  = 1'b0;
  logic              prev_rdv = 1'b0;

  cpu_req_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .OP_PULSE (OP_PULSE),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .CPU_Request (CPU_Request),
    .CPU_WE      (CPU_WE),
    .CPU_Address (CPU_Address),
    .CPU_WData   (CPU_WData),
    .CPU_RData   (CPU_RData),
    .CPU_ACK     (CPU_ACK),
    .OP_Request  (OP_Request),
    .OPERATIONS  (OPERATIONS),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .busy        (busy),
    .timeout_err (timeout_err),
    .illegal_err (illegal_err),
    .n_reads     (n_reads),
    .n_writes    (n_writes),
    .n_ops       (n_ops),
    .n_timeouts  (n_timeouts)
  );

  always #5 clk = ~clk;

  // VMEM responder and protocol monitor, evaluated on the falling edge
  always @(negedge clk) begin
    if (CPU_Request) begin
      req_cyc = req_cyc + 1;
      if (ack_en && req_cyc >= ack_delay) begin
        CPU_ACK   = 1'b1;
        CPU_RData = rdata_val;
      end
    end else begin
      CPU_ACK = 1'b0;
      req_cyc = 0;
    end
    if (CPU_Request && !prev_req) begin
      addr_log.push_back(CPU_Address);
      cap_we   = CPU_WE;
      cap_wd   = CPU_WData;
      cap_addr = CPU_Address;
    end
    if (CPU_Request && prev_req &&
        (CPU_WE != cap_we || CPU_WData != cap_wd || CPU_Address != cap_addr)) begin
      stab_err = stab_err + 1;
    end
    if (CPU_Request) begin
      req_run = req_run + 1;
    end else begin
      if (prev_req) last_req_len = req_run;
      req_run = 0;
    end
    if (OP_Request && !prev_op) op_codes.push_back(OPERATIONS);
    if (OP_Request) begin
      op_run = op_run + 1;
    end else begin
      if (prev_op) op_lens.push_back(op_run);
      op_run = 0;
    end
    if (rd_valid) begin
      rd_pulses = rd_pulses + 1;
      if (CPU_Request) rdv_req_err = rdv_req_err + 1;
      if (prev_rdv) rdv_long = rdv_long + 1;
    end
    prev_req = CPU_Request;
    prev_op  = OP_Request;
    prev_rdv = rd_valid;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered on a falling edge; returns on the falling edge after the accepting rising edge
  task automatic push(input logic [3:0] op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    logic acc;
    acc       = 1'b0;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && !CPU_ACK) break;
      @(negedge clk);
    end
    check_eq(tag, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int accepted;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_cpu_req", 64'(CPU_Request), 64'd0);
    check_eq("rst_op_req",  64'(OP_Request),  64'd0);
    check_eq("rst_busy",    64'(busy),        64'd0);
    check_eq("rst_ready",   64'(cmd_ready),   64'd1);
    check_eq("rst_errs",    64'({timeout_err, illegal_err, rd_valid, CPU_WE}), 64'd0);
    check_eq("rst_cnts",    64'({n_reads, n_writes, n_ops, n_timeouts}), 64'd0);

    // Read with a 3-cycle ack
    push(4'd0, 32'h0000_1234, '0);
    check_eq("issue_e0", 64'(CPU_Request), 64'd0);
    @(negedge clk);
    check_eq("issue_e1",  64'(CPU_Request), 64'd1);
    check_eq("rd_addr",   64'(CPU_Address), 64'h1234);
    check_eq("rd_we",     64'(CPU_WE),      64'd0);
    wait_idle("idle_rd", 100);
    check_eq("rd_pulses",  64'(rd_pulses),   64'd1);
    check_eq("rd_data",    64'(rd_data),     64'hDEAD_BEEF);
    check_eq("n_reads_1",  64'(n_reads),     64'd1);
    check_eq("rdv_width",  64'(rdv_long),    64'd0);
    check_eq("rdv_req_lo", 64'(rdv_req_err), 64'd0);

    // Write: WE/data stable for the whole request, no read return
    push(4'd1, 32'h0040_0000, 32'd2);
    wait_idle("idle_wr", 100);
    check_eq("wr_we",      64'(cap_we),      64'd1);
    check_eq("wr_wdata",   64'(cap_wd),      64'd2);
    check_eq("wr_addr",    64'(addr_log[$]), 64'h0040_0000);
    check_eq("wr_stable",  64'(stab_err),    64'd0);
    check_eq("n_writes_1", 64'(n_writes),    64'd1);
    check_eq("wr_no_rdv",  64'(rd_pulses),   64'd1);

    // Two operations back to back
    push(4'd8, '0, '0);
    push(4'd9, '0, '0);
    wait_idle("idle_ops", 200);
    check_eq("op_count", 64'(op_lens.size()), 64'd2);
    if (op_lens.size() >= 2 && op_codes.size() >= 2) begin
      check_eq("op_len0",  64'(op_lens[0]),  64'(OP_PULSE));
      check_eq("op_len1",  64'(op_lens[1]),  64'(OP_PULSE));
      check_eq("op_code0", 64'(op_codes[0]), 64'h8);
      check_eq("op_code1", 64'(op_codes[1]), 64'h9);
    end
    check_eq("n_ops_2",   64'(n_ops),      64'd2);
    check_eq("ops_hold",  64'(OPERATIONS), 64'h9);

    // Fill with ACK held off, then release and check ordering through the pointer wrap
    ack_en = 1'b0;
    addr_log.delete();
    accepted = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      cmd_op    = 4'd0;
      cmd_addr  = 32'h100 + 32'(k);
      cmd_data  = '0;
      cmd_valid = 1'b1;
      if (!cmd_ready) break;
      @(posedge clk);
      accepted = accepted + 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check_eq("fill_accepts", 64'(accepted),  64'(DEPTH + 1));
    check_eq("fill_ready",   64'(cmd_ready), 64'd0);
    ack_en = 1'b1;
    push(4'd0, 32'h105, '0);
    wait_idle("idle_fill", 600);
    check_eq("order_count", 64'(addr_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < addr_log.size()) check_eq($sformatf("order_%0d", i), 64'(addr_log[i]), 64'(32'h100 + 32'(i)));
    end
    check_eq("n_reads_7",    64'(n_reads),    64'd7);
    check_eq("fill_no_tmo",  64'(n_timeouts), 64'd0);

    // Timeout with ACK never returned, then a normal read
    ack_en = 1'b0;
    push(4'd0, 32'h200, '0);
    wait_idle("idle_tmo", 100);
    check_eq("tmo_req_len", 64'(last_req_len), 64'(TIMEOUT));
    check_eq("tmo_err",     64'(timeout_err),  64'd1);
    check_eq("n_timeouts",  64'(n_timeouts),   64'd1);
    check_eq("tmo_no_rdv",  64'(rd_pulses),    64'd7);
    check_eq("tmo_n_reads", 64'(n_reads),      64'd7);
    ack_en = 1'b1;
    push(4'd0, 32'h300, '0);
    wait_idle("idle_after_tmo", 100);
    check_eq("post_tmo_addr", 64'(addr_log[$]), 64'h300);
    check_eq("n_reads_8",     64'(n_reads),     64'd8);

    // Illegal op dropped, following read issues
    check_eq("illegal_pre", 64'(illegal_err), 64'd0);
    push(4'd5, '0, '0);
    push(4'd0, 32'h400, '0);
    wait_idle("idle_ill", 100);
    check_eq("illegal_err",  64'(illegal_err), 64'd1);
    check_eq("ill_rd_addr",  64'(addr_log[$]), 64'h400);
    check_eq("n_reads_9",    64'(n_reads),     64'd9);
    check_eq("ill_n_ops",    64'(n_ops),       64'd2);

    // Reset in the middle of a request with another command queued
    ack_en = 1'b0;
    push(4'd0, 32'h500, '0);
    push(4'd1, 32'h600, 32'd7);
    check_eq("rst_pre_req", 64'(CPU_Request), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_req",   64'(CPU_Request), 64'd0);
    check_eq("mid_rst_busy",  64'(busy),        64'd0);
    check_eq("mid_rst_ready", 64'(cmd_ready),   64'd1);
    check_eq("mid_rst_flags", 64'({timeout_err, illegal_err, rd_valid, CPU_WE, OP_Request}), 64'd0);
    check_eq("mid_rst_cnts",  64'({n_reads, n_writes, n_ops, n_timeouts}), 64'd0);
    check_eq("mid_rst_regs",  64'({CPU_Address, OPERATIONS}), 64'd0);
    check_eq("mid_rst_data",  64'({CPU_WData, rd_data}), 64'd0);
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("flushed_req",  64'(CPU_Request), 64'd0);
    check_eq("flushed_busy", 64'(busy),        64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_req_sequencer.md
# cpu_req_sequencer

Synthesizable, parametrised replacement for the trace-driving CPU stimulus in front of the paging system (VMEM). Commands (read, write, maintenance operation) are pushed into an internal FIFO. The block replays each command to VMEM: reads and writes use the four-phase CPU_Request/CPU_ACK handshake, and maintenance operations use a timed OP_Request pulse with the OPERATIONS code. It adds handshake timeouts, read-data return and saturating statistics counters, none of which the behavioural stimulus had.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 8, command FIFO entries (power of 2, ≥2)
- OP_PULSE, 10, OP_Request high time in cycles (≥1)
- TIMEOUT, 1024, maximum cycles waiting on CPU_ACK per phase; 0 disables the timeout
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  sole clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_op  in  4  0=read, 1=write, 2/3/4/8/9=operation, others illegal
- cmd_addr  in  ADDR_W  virtual address
- cmd_data  in  DATA_W  write data
- CPU_Request  out  1  request to VMEM
- CPU_WE  out  1  1=write, 0=read
- CPU_Address  out  ADDR_W  address to VMEM
- CPU_WData  out  DATA_W  write data, valid while CPU_Request&&CPU_WE
- CPU_RData  in  DATA_W  read data from VMEM, valid when CPU_ACK=1
- CPU_ACK  in  1  completion from VMEM
- OP_Request  out  1  operation strobe
- OPERATIONS  out  4  operation code
- rd_valid  out  1  one-cycle read-return pulse
- rd_data  out  DATA_W  captured read data
- busy  out  1  state≠IDLE or FIFO not empty
- timeout_err, illegal_err  out  1  sticky error flags
- n_reads, n_writes, n_ops, n_timeouts  out  CNT_W  saturating counters

## Operation
- FIFO push occurs on cmd_valid&&cmd_ready. cmd_ready=!full. A push while full is impossible and is not stored.
- State IDLE: when the FIFO is non-empty and CPU_ACK=0, pop the head entry and decode it.
  - Op 0/1: register CPU_Address, CPU_WE and CPU_WData, set CPU_Request=1, then go to REQ.
  - Op 2/3/4/8/9: register OPERATIONS, set OP_Request=1, load the pulse counter, then go to OPS.
  - Other op codes: discard the entry, set illegal_err, stay in IDLE.
- State REQ: address, WE and data are held stable.
  - On the edge that samples CPU_ACK=1: CPU_Request←0. For a read, rd_data←CPU_RData and rd_valid=1 for one cycle, and n_reads increments. For a write, n_writes increments. Go to REL.
- State REL: wait for CPU_ACK=0, then go to IDLE. The next command may issue on the following edge.
- State OPS: OP_Request stays high for exactly OP_PULSE cycles, then drops. n_ops increments and the state returns to IDLE. OPERATIONS holds its value until the next operation.
- Timeout: the wait counter clears on entry to REQ and to REL and increments each cycle while waiting.
  - If TIMEOUT≠0 and the count reaches TIMEOUT in REQ: CPU_Request←0, timeout_err←1, n_timeouts increments, no rd_valid pulse, go to REL.
  - If the count reaches TIMEOUT in REL: timeout_err←1, n_timeouts increments, go to IDLE.
- Counters saturate at 2^CNT_W−1. Error flags clear only on rst.
- A simultaneous push and pop in one cycle is legal. The FIFO count is unchanged and pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - CPU_Request, CPU_WE, OP_Request, rd_valid, busy, and both error flags are 0.
  - CPU_Address, CPU_WData, OPERATIONS, rd_data and all counters are 0.
  - FIFO is empty, cmd_ready=1, state is IDLE.
- rst asserted mid-handshake: on that edge all of the above values apply and FIFO contents are discarded.
- Issue latency: a command accepted at edge E0 into an idle, empty block has CPU_Request (or OP_Request) high after E1.
- Completion latency: CPU_ACK sampled high at edge Ea gives CPU_Request low and rd_valid high after Ea. rd_valid is low after Ea+1.
- Back-to-back: at least one idle cycle separates CPU_Request falling and the next assertion, because IDLE requires CPU_ACK=0.
- All outputs are registered. There is no combinational path from CPU_ACK to any output.

## Test plan
- Reset then push read 0x0000_1234 with a VMEM model acking 3 cycles after request and CPU_RData=0xDEAD_BEEF -> CPU_Request high after E1; rd_valid pulses once with rd_data=0xDEADBEEF; n_reads=1.
- Push write addr 0x0040_0000, data 2 -> CPU_WE=1 and CPU_WData=2 stable for the whole REQ phase; n_writes=1; rd_valid stays low.
- Push op 8, then op 9, with OP_PULSE=10 -> OP_Request high exactly 10 cycles per op, OPERATIONS=4'b1000 then 4'b1001; n_ops=2.
- Push DEPTH+1 commands with CPU_ACK held 0 -> cmd_ready drops after DEPTH accepts (accounting for the first pop); order is preserved on release; simultaneous push/pop wrap is correct.
- TIMEOUT=16 with CPU_ACK never asserted -> CPU_Request drops after 16 REQ cycles; timeout_err=1; n_timeouts=1; next command issues.
- Push op 5, then a read -> illegal_err=1 and op 5 is dropped; the read issues normally. Asserting rst during REQ -> all outputs at reset values on the next edge.
